commit_serializer: RTL

- Sits between a multi-retire core wrapper and the single-commit checker in the formal top.
- Accepts up to NRET committed instructions per cycle and buffers them in a DEPTH-entry FIFO.
- Presents them to the checker strictly one per cycle, in program order, with a valid/ready handshake.
- Generalises the one-commit-per-cycle direct hookup to multiple retire lanes, with buffering, backpressure and overflow detection.

---
 rtl/commit_serializer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/commit_serializer.sv
// commit_serializer: collects up to NRET retired instructions per cycle into a
// DEPTH-entry FIFO and hands them to a single-commit checker one per cycle,
// in program order, over a valid/ready handshake.
// Optional feature: define COMMIT_SER_PC_CHECK_EN to enable the pc continuity
// check that drives pc_mismatch; otherwise pc_mismatch is tied low.
module commit_serializer #(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [NRET-1:0]            in_valid,
    input  logic [NRET*XLEN-1:0]       in_inst,
    input  logic [NRET*XLEN-1:0]       in_pc,
    input  logic [NRET*XLEN-1:0]       in_next_pc,
    input  logic [NRET-1:0]            in_trap,
    input  logic [NRET*XLEN-1:0]       in_cause,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_inst,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_next_pc,
    output logic [XLEN-1:0]            out_cause,
    output logic                       out_trap,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       pc_mismatch
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int ENT_W = 4 * XLEN + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] NRET_C  = CW'(NRET);

    // Entry layout: {trap, cause, next_pc, pc, inst}
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic [CW-1:0]    w_lane_off [NRET];
    logic [PW-1:0]    w_wr_addr  [NRET];
    logic [CW-1:0]    w_npush;
    logic [CW-1:0]    w_count_nxt;
    logic             w_any_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf;
    logic [ENT_W-1:0] w_head;

    // Ready only looks at registered occupancy; a same-cycle pop is not credited.
    assign in_ready    = (DEPTH_C - r_count) >= NRET_C;
    assign out_valid   = (r_count != {CW{1'b0}});
    assign w_any_valid = |in_valid;
    assign w_push      = in_ready && w_any_valid && !flush;
    assign w_pop       = out_valid && out_ready && !flush;
    assign w_ovf       = w_any_valid && !in_ready && !flush;

    assign w_head      = r_mem[r_rd_ptr];
    assign out_inst    = w_head[XLEN-1:0];
    assign out_pc      = w_head[2*XLEN-1:XLEN];
    assign out_next_pc = w_head[3*XLEN-1:2*XLEN];
    assign out_cause   = w_head[4*XLEN-1:3*XLEN];
    assign out_trap    = w_head[4*XLEN];
    assign count       = r_count;
    assign overflow    = r_overflow;

    // Compact valid lanes: each lane's slot offset is the number of valid older lanes.
    always_comb begin
        w_npush = {CW{1'b0}};
        for (int i = 0; i < NRET; i++) begin
            w_lane_off[i] = w_npush;
            w_wr_addr[i]  = r_wr_ptr + w_npush[PW-1:0];
            if (in_valid[i]) begin
                w_npush = w_npush + CW'(1'b1);
            end else begin
                w_npush = w_npush;
            end
        end
    end

    // Next occupancy: push and pop in the same cycle are both honoured.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = {CW{1'b0}};
        end else begin
            w_count_nxt = r_count + (w_push ? w_npush : {CW{1'b0}})
                                  - (w_pop ? CW'(1'b1) : {CW{1'b0}});
        end
    end

    // Entry storage; cleared at reset so the data outputs start at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= {ENT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NRET; i++) begin
                if (w_push && in_valid[i]) begin
                    r_mem[w_wr_addr[i]] <= {in_trap[i],
                                            in_cause[i*XLEN +: XLEN],
                                            in_next_pc[i*XLEN +: XLEN],
                                            in_pc[i*XLEN +: XLEN],
                                            in_inst[i*XLEN +: XLEN]};
                end
            end
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= {PW{1'b0}};
            r_rd_ptr   <= {PW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (flush) begin
                r_wr_ptr <= {PW{1'b0}};
                r_rd_ptr <= {PW{1'b0}};
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + w_npush[PW-1:0];
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1'b1);
                end
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef COMMIT_SER_PC_CHECK_EN
    logic [XLEN-1:0] r_last_npc;
    logic            r_last_npc_vld;
    logic            r_pc_mismatch;

    // Continuity check: each popped pc must equal the previous pop's next pc.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_npc     <= {XLEN{1'b0}};
            r_last_npc_vld <= 1'b0;
            r_pc_mismatch  <= 1'b0;
        end else if (flush) begin
            r_last_npc_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_last_npc_vld && (out_pc != r_last_npc)) begin
                r_pc_mismatch <= 1'b1;
            end
            r_last_npc     <= out_next_pc;
            r_last_npc_vld <= 1'b1;
        end
    end

    assign pc_mismatch = r_pc_mismatch;
`else
    assign pc_mismatch = 1'b0;
`endif

endmodule
